gold_nic: RTL

- Processor-side network interface for the bidirectional ring NoC.
- Mates with a router's PE port: it is the sender the router's PE input receives from, and the receiver the router's PE output sends to.
- Presents a 4-entry, 64-bit register map to the local processor.
- Holds one outbound packet and one inbound packet, each in a 1-entry channel buffer.
- Injects outbound packets only in the ring phase that matches the packet's virtual channel.

---
 rtl/gold_nic_pkg.sv | 16 +
 rtl/gold_nic_if.sv | 26 ++
 rtl/gold_nic_slot.sv | 22 ++
 rtl/gold_nic.sv | 72 +++++++
 4 files changed

// File: rtl/gold_nic_pkg.sv
// Shared NoC package: NIC register map, header bit positions and packet type.
package gold_noc_pkg;

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  localparam int HDR_VC     = 31;
  localparam int HDR_DIR    = 30;
  localparam int HDR_HOP_HI = 25;
  localparam int HDR_HOP_LO = 18;

  typedef logic [63:0] pkt_t;

endpackage

// File: rtl/gold_nic_if.sv
// NIC bus bundle: processor register port plus router PE-port handshakes.
// slave is the NIC's view; master is the processor/router side.
interface gold_nic_if #(parameter int DATA_W = 64);
  logic [1:0]        addr;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] d_out;
  logic              nicEn;
  logic              nicWrEn;
  logic              net_si;
  logic              net_ri;
  logic [DATA_W-1:0] net_di;
  logic              net_so;
  logic              net_ro;
  logic [DATA_W-1:0] net_do;
  logic              net_polarity;

  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/gold_nic_slot.sv
// One-entry packet buffer with full flag; load wins over clear if both strobe.
module nic_slot #(parameter int W = 64) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         full,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (clr) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/gold_nic.sv
// Ring-NoC processor NIC: one inbound and one outbound slot, phase-gated injection.
// Optional NIC_STATS_EN adds tx/rx transfer counters and an extended in-status word.
module gold_nic
  import gold_noc_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int VC_BIT = HDR_VC,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
`ifdef NIC_STATS_EN
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
`endif
  gold_nic_if.slave        bus
);
  logic              in_full, out_full;
  logic [DATA_W-1:0] in_buf, out_buf;
  logic              rd, wr, in_load, in_clr, out_load, out_clr;

  assign rd = bus.nicEn & ~bus.nicWrEn;
  assign wr = bus.nicEn &  bus.nicWrEn;

  assign in_load  = bus.net_si & ~in_full;
  assign in_clr   = rd & (bus.addr == ADDR_IN_BUF) & in_full;
  assign out_load = wr & (bus.addr == ADDR_OUT_BUF) & ~out_full;
  assign out_clr  = bus.net_so & bus.net_ro;

  nic_slot #(.W(DATA_W)) u_in (
    .clk(clk), .reset(reset), .load(in_load), .clr(in_clr),
    .d(bus.net_di), .full(in_full), .q(in_buf)
  );

  nic_slot #(.W(DATA_W)) u_out (
    .clk(clk), .reset(reset), .load(out_load), .clr(out_clr),
    .d(bus.d_in), .full(out_full), .q(out_buf)
  );

  assign bus.net_ri = ~in_full;
  assign bus.net_do = out_buf;
  // Inject only in the ring phase matching the packet's virtual channel.
  assign bus.net_so = out_full & (bus.net_polarity == out_buf[VC_BIT]);

`ifdef NIC_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      if (out_clr) tx_count <= tx_count + 1'b1;
      if (in_load) rx_count <= rx_count + 1'b1;
    end
  end
`endif

  always_comb begin
    bus.d_out = '0;
    if (rd) begin
      case (bus.addr)
        ADDR_IN_BUF:  bus.d_out = in_buf;
`ifdef NIC_STATS_EN
        ADDR_IN_STAT: bus.d_out = {rx_count, {(DATA_W-CNT_W-1){1'b0}}, in_full};
`else
        ADDR_IN_STAT: bus.d_out = {{(DATA_W-1){1'b0}}, in_full};
`endif
        ADDR_OUT_BUF: bus.d_out = out_buf;
        default:      bus.d_out = {{(DATA_W-1){1'b0}}, out_full};
      endcase
    end
  end
endmodule
